// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: request bundle and owner-id type.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ARB_NUM_REQ = 4;
  localparam int unsigned DMEM_ARB_ID_W    = $clog2(DMEM_ARB_NUM_REQ);

  typedef logic [DMEM_ARB_ID_W-1:0] dmem_arb_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        byte_not_word;
  } dmem_req_s;

endpackage

// File: rtl/rr_arbiter.sv
// Generic combinational round-robin arbiter: first request at or after ptr_i wins.
module rr_arbiter #(
  parameter int n_p    = 4,
  parameter int id_w_p = $clog2(n_p)
) (
  input  logic [n_p-1:0]    req_i,
  input  logic [id_w_p-1:0] ptr_i,
  output logic [n_p-1:0]    grant_o,
  output logic [id_w_p-1:0] id_o,
  output logic              any_o
);

  always_comb begin : scan
    int idx;
    any_o = 1'b0;
    id_o  = '0;
    idx   = 0;
    for (int k = 0; k < n_p; k++) begin
      idx = (int'(ptr_i) + k) % n_p;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        id_o  = id_w_p'(idx);
      end else begin
        any_o = any_o;
      end
    end
    grant_o = any_o ? (n_p'(1) << id_o) : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port among several cores; an in-order owner FIFO
// routes each memory response back to the core that issued the request.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int num_req_p   = 4,
  parameter int max_outst_p = 2,
  parameter int id_width_p  = $clog2(num_req_p)
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [num_req_p-1:0]       req_valid_i,
  input  logic [num_req_p-1:0]       req_wen_i,
  input  logic [num_req_p-1:0]       req_byte_i,
  input  logic [num_req_p-1:0][31:0] req_addr_i,
  input  logic [num_req_p-1:0][31:0] req_wdata_i,
  output logic [num_req_p-1:0]       req_yumi_o,
  output logic [num_req_p-1:0]       resp_valid_o,
  output logic [31:0]                resp_data_o,
  input  logic [num_req_p-1:0]       resp_yumi_i,
  output logic                       mem_valid_o,
  output logic                       mem_wen_o,
  output logic                       mem_byte_o,
  output logic [31:0]                mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  input  logic                       mem_yumi_i,
  input  logic                       mem_resp_valid_i,
  input  logic [31:0]                mem_resp_data_i,
  output logic                       mem_resp_yumi_o,
  output logic                       protocol_err_o
);

  localparam int ptr_w_lp = (max_outst_p > 1) ? $clog2(max_outst_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outst_p + 1);
  localparam logic [cnt_w_lp-1:0]   max_cnt_lp  = cnt_w_lp'(max_outst_p);
  localparam logic [ptr_w_lp-1:0]   last_ptr_lp = ptr_w_lp'(max_outst_p - 1);
  localparam logic [id_width_p-1:0] last_id_lp  = id_width_p'(num_req_p - 1);

  function automatic logic [num_req_p-1:0] onehot_id(input logic [id_width_p-1:0] id);
    onehot_id = num_req_p'(1) << id;
  endfunction

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    ptr_inc = (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  logic [id_width_p-1:0] rr_ptr_q, rr_ptr_d;
  logic                  lock_q, lock_d;
  logic [id_width_p-1:0] lock_id_q, lock_id_d;
  logic [id_width_p-1:0] fifo_q [max_outst_p];
  logic [id_width_p-1:0] fifo_d [max_outst_p];
  logic [ptr_w_lp-1:0]   head_q, head_d, tail_q, tail_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic                  err_q, err_d;

  logic [num_req_p-1:0]  arb_grant_s, win_onehot_s;
  logic [id_width_p-1:0] arb_id_s, win_id_s, head_id_s;
  logic                  arb_any_s, win_valid_s, accept_s, resp_active_s, pop_s;
  dmem_req_s             win_req_s;

  rr_arbiter #(.n_p(num_req_p), .id_w_p(id_width_p)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant_s),
    .id_o    (arb_id_s),
    .any_o   (arb_any_s)
  );

  // A stalled grant stays locked on its core so the memory sees a stable request.
  always_comb begin
    win_id_s     = lock_q ? lock_id_q : arb_id_s;
    win_onehot_s = lock_q ? onehot_id(lock_id_q) : arb_grant_s;
    win_valid_s  = lock_q ? req_valid_i[lock_id_q] : arb_any_s;
    win_req_s    = '{addr: req_addr_i[win_id_s], wdata: req_wdata_i[win_id_s],
                     wen: req_wen_i[win_id_s], byte_not_word: req_byte_i[win_id_s]};

    mem_valid_o  = win_valid_s && (count_q < max_cnt_lp);
    accept_s     = mem_valid_o && mem_yumi_i;
    mem_addr_o   = mem_valid_o ? win_req_s.addr  : 32'h0000_0000;
    mem_wdata_o  = mem_valid_o ? win_req_s.wdata : 32'h0000_0000;
    mem_wen_o    = mem_valid_o ? win_req_s.wen   : 1'b0;
    mem_byte_o   = mem_valid_o ? win_req_s.byte_not_word : 1'b0;
    req_yumi_o   = accept_s ? win_onehot_s : '0;

    head_id_s       = fifo_q[head_q];
    resp_active_s   = mem_resp_valid_i && (count_q != '0);
    resp_valid_o    = resp_active_s ? onehot_id(head_id_s) : '0;
    mem_resp_yumi_o = resp_active_s && resp_yumi_i[head_id_s];
    pop_s           = mem_resp_yumi_o;
    resp_data_o     = mem_resp_data_i;
    protocol_err_o  = err_q;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    tail_d    = tail_q;
    head_d    = pop_s ? ptr_inc(head_q) : head_q;
    err_d     = err_q | (mem_resp_valid_i && (count_q == '0));
    if (accept_s) begin
      rr_ptr_d       = (win_id_s == last_id_lp) ? '0 : win_id_s + id_width_p'(1);
      lock_d         = 1'b0;
      fifo_d[tail_q] = win_id_s;
      tail_d         = ptr_inc(tail_q);
    end else if (mem_valid_o) begin
      lock_d    = 1'b1;
      lock_id_d = win_id_s;
    end else begin
      lock_d = lock_q;
    end
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < max_outst_p; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
    end
  end

endmodule
